// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the shared-multiplier controller.
//   W      operand width (product is 2*W bits)
//   N_REQ  number of requesters sharing the multiplier
//   ID_W   width of a requester index
//   s1_entry_t  contents of the operand stage: {a, b, id}
package mul_pkg;

    localparam int W     = 16;
    localparam int N_REQ = 4;
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic [ID_W-1:0]     id;
    } s1_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req     [N_REQ]  request vector
//   ptr     [ID_W]   index of the last granted requester; search starts at ptr+1
//   en               when low, gnt is all zero (gnt_id still reports the winner)
//   gnt     [N_REQ]  one-hot grant (zero when en=0 or no request)
//   gnt_id  [ID_W]   encoded index of the winner (0 when no request)
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    // One extra bit so ptr + k (k up to N_REQ) never overflows before the wrap.
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        sum    = '0;
        idx    = '0;
        found  = 1'b0;
        gnt_id = '0;
        // Visit ptr+1, ptr+2, ... wrapping modulo N_REQ; ptr itself is visited last.
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        gnt = (en && found) ? (N_REQ'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one combinational signed multiplier among N_REQ
// requesters with round-robin arbitration and a two-stage pipeline
// (S1 operand register driving the multiplier, S2 product register).
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (at most one ready bit high)
//   req_a/req_b            packed operands, requester i at [i*W +: W]
//   mul_a/mul_b            operands to the external multiplier (0 when S1 empty)
//   mul_p                  product returned combinationally by the multiplier
//   rsp_valid/rsp_ready    response handshake with backpressure
//   rsp_id/rsp_p           owner index and 2*W-bit signed product
module mul_share_ctrl
    import mul_pkg::*;
#(
    // The S1 entry type is sized by mul_pkg, so these must match the package.
    parameter int N_REQ = mul_pkg::N_REQ,
    parameter int W     = mul_pkg::W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W-1:0]        req_a,
    input  logic [N_REQ*W-1:0]        req_b,
    output logic [W-1:0]              mul_a,
    output logic [W-1:0]              mul_b,
    input  logic [2*W-1:0]            mul_p,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [mul_pkg::ID_W-1:0]  rsp_id,
    output logic [2*W-1:0]            rsp_p
);

    s1_entry_t            s1_q, s1_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]      s2_id_q, s2_id_d;
    logic signed [2*W-1:0] s2_p_q, s2_p_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 s2_free, s1_adv, s1_free;
    logic                 arb_en, accept;
    logic [N_REQ-1:0]     gnt;
    logic [ID_W-1:0]      gnt_id;

    assign s2_free = !s2_valid_q || rsp_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s1_adv;

    // req_ready must read 0 while reset is held, even though S1 is empty then.
    assign arb_en  = s1_free && rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_p_d     = s2_p_q;
        rr_ptr_d   = rr_ptr_q;

        // S1 -> S2: product is taken straight from the multiplier.
        if (s1_adv) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b1;
            s2_id_d    = s1_q.id;
            s2_p_d     = mul_p;
        end else if (rsp_ready) begin
            s2_valid_d = 1'b0;
        end

        // Request -> S1: may coincide with the S1 advance above.
        if (accept) begin
            s1_d.a     = req_a[gnt_id*W +: W];
            s1_d.b     = req_b[gnt_id*W +: W];
            s1_d.id    = gnt_id;
            s1_valid_d = 1'b1;
            rr_ptr_d   = gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
            rr_ptr_q   <= ID_W'(N_REQ - 1);
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_p_q     <= s2_p_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Multiplier inputs are held at zero whenever S1 holds nothing.
    assign mul_a     = s1_valid_q ? s1_q.a : '0;
    assign mul_b     = s1_valid_q ? s1_q.b : '0;

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_p     = s2_p_q;

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Shares one combinational 16x16 signed multiplier (Booth encoder + wallace_16_16 + adder32, result on add_out) among N_REQ requesters.
- Round-robin arbitration on a valid/ready request interface.
- Two-stage pipeline: operand register, then result register.
- Single tagged response port with backpressure. Sits between the client blocks and the multiplier datapath; it is the only driver of the multiplier operands.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 16, operand width; result width is 2*W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_a  input  N_REQ*W  packed operand A, requester i at [i*W +: W].
- req_b  input  N_REQ*W  packed operand B, same packing.
- mul_a  output  W  operand A to the multiplier.
- mul_b  output  W  operand B to the multiplier.
- mul_p  input  2*W  multiplier product (add_out), combinational from mul_a/mul_b.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  index of the requester that owns rsp_p; ID_W = clog2(N_REQ).
- rsp_p  output  2*W  product, signed two's complement.

Behaviour:
- Reset is asynchronous on rst_n low. During and after reset: s1_valid=0, s2_valid=0, rsp_valid=0, req_ready=0, rsp_id=0, rsp_p=0, mul_a=0, mul_b=0, rr_ptr=N_REQ-1 (requester 0 has first priority).
- Stage S1 holds a, b and id. mul_a/mul_b come from the S1 registers when s1_valid=1 and are forced to 0 when s1_valid=0.
- Stage S2 holds id and the product. It captures mul_p when S1 advances. rsp_valid=s2_valid, rsp_id=s2_id, rsp_p=s2_p.
- Stall and advance conditions:
  - s2_free = !s2_valid | rsp_ready.
  - s1_adv = s1_valid & s2_free.
  - s1_free = !s1_valid | s1_adv.
- Arbitration: grant = the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo N_REQ. req_ready[grant]=s1_free; all other req_ready bits are 0. req_ready may depend on req_valid.
- Handshake: the request is accepted when req_valid[i] & req_ready[i]. On acceptance, S1 loads {req_a[i], req_b[i], i}, s1_valid=1 and rr_ptr=i. rr_ptr changes only on an accepted handshake.
- Latency: accepted at edge t, rsp_valid at edge t+2 if rsp_ready stays high. Throughput is 1 op/cycle.
- Backpressure: while rsp_valid & !rsp_ready, S2 holds and S1 holds if valid, so at most 2 ops are in flight. rsp_id and rsp_p stay stable while rsp_valid is high and not accepted.
- Simultaneous events: S2 drain, S1 advance and a new acceptance in the same cycle are all legal and lose no data.
- S2 empty: s2_valid=0 => s1_adv=s1_valid regardless of rsp_ready.
- Requester dropping valid before acceptance: no state change; arbitration re-evaluates the next cycle.
- Requester i not changing req_a/req_b while valid and not ready: not required; the values are sampled at acceptance only.
- Reset mid-operation: all in-flight ops are discarded with no response; after release, operation restarts per the reset values above.
- Ordering: responses leave in acceptance order. No reordering, no dropping.
- Arithmetic: the block passes mul_p through unmodified. The product is correct only for the 2*W-bit signed product the datapath produces; the block does no truncation or extension.

Decomposition:
- Package mul_pkg: W, N_REQ, ID_W, and the typedef of the S1 entry {a, b, id}.
- One sub-module, rr_arbiter (N_REQ): inputs req, ptr, en; outputs one-hot gnt and encoded gnt_id. It is purely combinational. rr_ptr stays in mul_share_ctrl.
- mul_share_ctrl does not instantiate the multiplier. The bench and top level connect mul_a/mul_b/mul_p to it.

Test Plan:
- Single request: req_valid=4'b0001, a=16'h0003, b=16'hFFFE, rsp_ready=1 -> req_ready[0] high at cycle 0; rsp_valid two cycles later with rsp_id=0, rsp_p=32'hFFFF_FFFA.
- Round-robin: all 4 valid continuously after reset -> grant order 0,1,2,3,0 across 5 consecutive cycles; one response per cycle after a 2-cycle fill, ids in the same order.
- Backpressure: 3 back-to-back requests with rsp_ready=0 -> third is not accepted (req_ready=0); first response held stable; raise rsp_ready -> responses in order, none lost or duplicated.
- Signed corners via the real multiplier: 16'h8000*16'h8000 -> 32'h4000_0000; 16'h7FFF*16'h8000 -> 32'hC000_8000; 0*16'h1234 -> 0.
- Pointer hold: only requester 2 valid for 3 ops, then 1 and 3 valid together -> requester 3 is granted first, then 1.
- Reset mid-flight: assert rst_n=0 with both stages full -> rsp_valid, req_ready, mul_a and mul_b go to 0 immediately (asynchronous); after release, the first grant goes to requester 0.
